fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_pkg.sv | 35 +++
 rtl/fp_addsub_pipe_if.sv | 18 +
 rtl/fp_lzc.sv | 18 +
 rtl/fp_addsub_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: flag indices, rounding-mode codes and
// canonical special-value encodings for any {sign, exp, frac} layout up to 64 bits.
package fp_pkg;

   localparam int unsigned FLAG_W         = 4;
   localparam int unsigned FLAG_INEXACT   = 0;
   localparam int unsigned FLAG_UNDERFLOW = 1;
   localparam int unsigned FLAG_OVERFLOW  = 2;
   localparam int unsigned FLAG_INVALID   = 3;

   localparam logic [1:0] RM_RNE = 2'd0;
   localparam logic [1:0] RM_RTZ = 2'd1;
   localparam logic [1:0] RM_RDN = 2'd2;
   localparam logic [1:0] RM_RUP = 2'd3;

   // Flag bundle in the order it appears on the flags port.
   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   // Canonical quiet NaN: exponent all ones, only the fraction MSB set.
   function automatic logic [63:0] qnan_bits(input int unsigned exp_w, input int unsigned mant_w);
      return (((64'd1 << exp_w) - 64'd1) << mant_w) | (64'd1 << (mant_w - 1));
   endfunction

   // Signed infinity: exponent all ones, zero fraction.
   function automatic logic [63:0] inf_bits(input logic sign, input int unsigned exp_w,
                                            input int unsigned mant_w);
      return (((64'd1 << exp_w) - 64'd1) << mant_w) | (64'(sign) << (exp_w + mant_w));
   endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result stream bundle for fp_addsub_pipe.
// master: drives operands and out_ready; slave: the adder.
interface fp_addsub_pipe_if #(parameter int unsigned W = 16);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         op_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (output in_valid, a, b, op_sub, out_ready,
                   input  in_ready, out_valid, result, flags);
   modport slave  (input  in_valid, a, b, op_sub, out_ready,
                   output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter. din: vector to scan; cnt: number of zeros above the
// most significant set bit (WIDTH when din is zero).
module fp_lzc #(
   parameter int unsigned WIDTH = 14
) (
   input  logic [WIDTH-1:0]           din,
   output logic [$clog2(WIDTH+1)-1:0] cnt
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   // Scan upward so the highest set bit determines the final count.
   always_comb begin
      cnt = CNT_W'(WIDTH);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (((din >> i) & WIDTH'(1)) != '0) cnt = CNT_W'(WIDTH - 1 - i);
      end
   end
endmodule

// File: rtl/fp_addsub_pipe.sv
// 3-stage IEEE-style floating-point adder/subtractor, round-to-nearest-even.
// Ports: clk, rst_n (synchronous, active low), bus (slave): in_valid/in_ready,
// a, b, op_sub in; out_valid/out_ready, result, flags {invalid, overflow,
// underflow, inexact} out. in_ready is combinational from out_ready.
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W  = 5,
   parameter int unsigned MANT_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   fp_addsub_pipe_if.slave   bus
);
   localparam int unsigned W     = 1 + EXP_W + MANT_W;
   localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
   localparam int unsigned SIG_W = MANT_W + 4;   // hidden + fraction + guard/round/sticky
   localparam int unsigned SUM_W = MANT_W + 5;   // plus carry
   localparam int unsigned CNT_W = $clog2(SIG_W + 1);
   localparam int unsigned SAT   = MANT_W + 3;
   localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(2 * BIAS + 1);

   logic adv;

   // ---------------- S1: unpack, special detect, swap, align ----------------
   logic              sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap;
   logic [EXP_W-1:0]  ea, eb, el, es, eff_l, eff_s;
   logic [MANT_W-1:0] fa, fb, fl, fs;
   logic [31:0]       sh_amt;
   logic [SIG_W-1:0]  ext_s;
   logic [2*SIG_W-1:0] wide;
   logic              spec_c, spec_inv_c;
   logic [W-1:0]      spec_res_c;

   assign sa = bus.a[W-1];
   assign ea = bus.a[W-2:MANT_W];
   assign fa = bus.a[MANT_W-1:0];
   assign sb = bus.b[W-1] ^ bus.op_sub;   // subtraction is addition of -b
   assign eb = bus.b[W-2:MANT_W];
   assign fb = bus.b[MANT_W-1:0];

   assign a_nan  = (ea == EXP_ONES) && (fa != '0);
   assign b_nan  = (eb == EXP_ONES) && (fb != '0);
   assign a_snan = a_nan && !fa[MANT_W-1];
   assign b_snan = b_nan && !fb[MANT_W-1];
   assign a_inf  = (ea == EXP_ONES) && (fa == '0);
   assign b_inf  = (eb == EXP_ONES) && (fb == '0);

   // Raw exponent:fraction fields order the same as magnitudes.
   assign swap  = bus.b[W-2:0] > bus.a[W-2:0];
   assign el    = swap ? eb : ea;
   assign es    = swap ? ea : eb;
   assign fl    = swap ? fb : fa;
   assign fs    = swap ? fa : fb;
   assign eff_l = (el == '0) ? EXP_W'(1) : el;
   assign eff_s = (es == '0) ? EXP_W'(1) : es;

   // Far-apart operands saturate the shift; everything lost lands in sticky.
   always_comb begin
      sh_amt = 32'(eff_l) - 32'(eff_s);
      if (sh_amt >= 32'(SAT)) sh_amt = 32'(SAT);
      ext_s = {(es != '0), fs, 3'b000};
      wide  = {ext_s, SIG_W'(0)} >> sh_amt;
   end

   // NaN beats Inf; opposite infinities are invalid.
   always_comb begin
      spec_c     = 1'b0;
      spec_inv_c = 1'b0;
      spec_res_c = '0;
      if (a_nan || b_nan) begin
         spec_c     = 1'b1;
         spec_res_c = W'(qnan_bits(EXP_W, MANT_W));
         spec_inv_c = a_snan || b_snan;
      end else if (a_inf && b_inf && (sa != sb)) begin
         spec_c     = 1'b1;
         spec_res_c = W'(qnan_bits(EXP_W, MANT_W));
         spec_inv_c = 1'b1;
      end else if (a_inf) begin
         spec_c     = 1'b1;
         spec_res_c = W'(inf_bits(sa, EXP_W, MANT_W));
      end else if (b_inf) begin
         spec_c     = 1'b1;
         spec_res_c = W'(inf_bits(sb, EXP_W, MANT_W));
      end
   end

   logic              v1, s1_sign, s1_sub, s1_zsign, s1_spec, s1_spec_inv;
   logic [EXP_W-1:0]  s1_exp;
   logic [SIG_W-1:0]  s1_sig_l, s1_sig_s;
   logic [W-1:0]      s1_spec_res;

   always_ff @(posedge clk) begin
      if (!rst_n)   v1 <= 1'b0;
      else if (adv) v1 <= bus.in_valid;
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_sign     <= swap ? sb : sa;
         s1_sub      <= sa ^ sb;
         s1_zsign    <= sa & sb;   // exact zero is -0 only when both addends are -0
         s1_exp      <= eff_l;
         s1_sig_l    <= {(el != '0), fl, 3'b000};
         s1_sig_s    <= {wide[2*SIG_W-1:SIG_W+1], wide[SIG_W] | (|wide[SIG_W-1:0])};
         s1_spec     <= spec_c;
         s1_spec_inv <= spec_inv_c;
         s1_spec_res <= spec_res_c;
      end
   end

   // ---------------- S2: magnitude add / subtract ----------------
   logic              v2, s2_sign, s2_zsign, s2_spec, s2_spec_inv;
   logic [EXP_W-1:0]  s2_exp;
   logic [SUM_W-1:0]  s2_sum;
   logic [W-1:0]      s2_spec_res;

   always_ff @(posedge clk) begin
      if (!rst_n)   v2 <= 1'b0;
      else if (adv) v2 <= v1;
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s2_sum      <= s1_sub ? ({1'b0, s1_sig_l} - {1'b0, s1_sig_s})
                               : ({1'b0, s1_sig_l} + {1'b0, s1_sig_s});
         s2_exp      <= s1_exp;
         s2_sign     <= s1_sign;
         s2_zsign    <= s1_zsign;
         s2_spec     <= s1_spec;
         s2_spec_inv <= s1_spec_inv;
         s2_spec_res <= s1_spec_res;
      end
   end

   // ---------------- S3: normalise, round, pack ----------------
   logic [CNT_W-1:0]  lz;
   logic [31:0]       shl, lim;
   logic [SIG_W-1:0]  mant;
   logic [EXP_W:0]    exp_n, exp_o;
   logic [MANT_W+1:0] rounded;
   logic              rup, inexact;
   logic [W-1:0]      res_c;
   fp_flags_t         flags_c;

   fp_lzc #(.WIDTH(SIG_W)) u_lzc (
      .din (s2_sum[SIG_W-1:0]),
      .cnt (lz)
   );

   always_comb begin
      shl   = '0;
      lim   = 32'(s2_exp) - 32'd1;
      mant  = s2_sum[SIG_W-1:0];
      exp_n = (EXP_W+1)'(s2_exp);
      if (s2_sum[SUM_W-1]) begin
         // Carry out: shift right one, folding the dropped bit into sticky.
         mant  = {s2_sum[SUM_W-1:2], s2_sum[1] | s2_sum[0]};
         exp_n = (EXP_W+1)'(s2_exp) + (EXP_W+1)'(1);
      end else begin
         // Left shift limited so the exponent bottoms out at 1 (subnormal).
         shl   = (32'(lz) < lim) ? 32'(lz) : lim;
         mant  = s2_sum[SIG_W-1:0] << shl;
         exp_n = (EXP_W+1)'(32'(s2_exp) - shl);
      end

      inexact = |mant[2:0];
      rup     = mant[2] & (mant[1] | mant[0] | mant[3]);
      rounded = {1'b0, mant[SIG_W-1:3]} + (MANT_W+2)'(rup);

      // Rounding carry bumps the exponent; a missing hidden bit means subnormal.
      if (rounded[MANT_W+1])   exp_o = exp_n + (EXP_W+1)'(1);
      else if (rounded[MANT_W]) exp_o = exp_n;
      else                      exp_o = '0;

      flags_c = '0;
      if (s2_spec) begin
         res_c           = s2_spec_res;
         flags_c.invalid = s2_spec_inv;
      end else if (exp_o >= {1'b0, EXP_ONES}) begin
         res_c            = W'(inf_bits(s2_sign, EXP_W, MANT_W));
         flags_c.overflow = 1'b1;
         flags_c.inexact  = 1'b1;
      end else if (rounded == '0) begin
         res_c = {s2_zsign, (W-1)'(0)};
      end else begin
         res_c             = {s2_sign, exp_o[EXP_W-1:0], rounded[MANT_W-1:0]};
         flags_c.inexact   = inexact;
         flags_c.underflow = inexact && (exp_o == '0);
      end
   end

   // ---------------- Output register and handshake ----------------
   logic         out_valid_q;
   logic [W-1:0] result_q;
   logic [3:0]   flags_q;

   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else if (adv) begin
         out_valid_q <= v2;
         if (v2) begin
            result_q <= res_c;
            flags_q  <= flags_c;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe in fp16 configuration.
module tb_fp_addsub_pipe;

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  fl;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp_addsub_pipe_if #(.W(16)) bus ();

   fp_addsub_pipe #(.EXP_W(5), .MANT_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   n_push = 0;
   int   n_pop  = 0;
   bit   push_en = 1'b1;
   exp_t exp_q[$];
   int   id_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Present one operation and hold it until accepted; record its expectation.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                       input logic [15:0] r, input logic [3:0] f, input int id);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      bus.a = a;
      bus.b = b;
      bus.op_sub = op;
      bus.in_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         if (bus.in_ready) acc = 1'b1;
         @(posedge clk);
         n++;
      end
      if (!acc) check($sformatf("op%0d accept timeout", id), 32'd0, 32'd1);
      else if (push_en) begin
         exp_q.push_back('{res: r, fl: f});
         id_q.push_back(id);
         n_push++;
      end
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops on every completed output; checks stability while stalled.
   exp_t        e;
   int          eid;
   bit          held = 1'b0;
   logic [15:0] held_res;
   logic [3:0]  held_fl;

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (bus.out_ready) begin
            held = 1'b0;
            n_pop++;
            if (exp_q.size() == 0) begin
               check("unexpected output", 32'(bus.result), 32'hFFFF_FFFF);
            end else begin
               e   = exp_q.pop_front();
               eid = id_q.pop_front();
               check($sformatf("op%0d result", eid), 32'(bus.result), 32'(e.res));
               check($sformatf("op%0d flags", eid), 32'(bus.flags), 32'(e.fl));
            end
         end else begin
            if (held) begin
               check("stall result stable", 32'(bus.result), 32'(held_res));
               check("stall flags stable", 32'(bus.flags), 32'(held_fl));
            end
            held     = 1'b1;
            held_res = bus.result;
            held_fl  = bus.flags;
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.op_sub = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset result", 32'(bus.result), 32'd0);
      check("reset flags", 32'(bus.flags), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready after reset", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // 1.0 + 1.0 with exact 3-cycle latency.
      send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'h0, 1);
      @(negedge clk);
      check("latency cycle 1", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("latency cycle 2", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("latency cycle 3", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;

      // Directed vectors, streamed back to back.
      send(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'h1, 2);   // tie, stays even
      send(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'h1, 3);   // tie, rounds up to even
      send(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'h8, 4);   // inf - inf
      send(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5, 5);   // overflow
      send(16'h0001, 16'h0001, 1'b0, 16'h0002, 4'h0, 6);   // subnormals
      send(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'h0, 7);   // x - x = +0
      send(16'h8000, 16'h8000, 1'b0, 16'h8000, 4'h0, 8);   // -0 + -0
      send(16'h8000, 16'h0000, 1'b1, 16'h8000, 4'h0, 9);   // -0 - +0
      send(16'h0000, 16'h0000, 1'b1, 16'h0000, 4'h0, 10);  // +0 - +0
      send(16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'h0, 11);  // qNaN in
      send(16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 4'h8, 12);  // sNaN in
      send(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'h0, 13);  // inf + finite
      send(16'hFC00, 16'h3C00, 1'b1, 16'hFC00, 4'h0, 14);  // -inf - finite
      send(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'h0, 15);  // 1 - 2 = -1
      send(16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'h0, 16);  // normal -> subnormal
      send(16'h3C00, 16'h0001, 1'b0, 16'h3C00, 4'h1, 17);  // saturated shift, sticky
      send(16'h4000, 16'hC000, 1'b0, 16'h0000, 4'h0, 18);  // 2 + -2 = +0
      send(16'h03FF, 16'h0001, 1'b0, 16'h0400, 4'h0, 19);  // subnormal -> normal
      drain();

      // Six ops against a stalled output.
      bus.out_ready = 1'b0;
      fork
         begin
            send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'h0, 20);
            send(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'h0, 21);
            send(16'h4200, 16'h3C00, 1'b0, 16'h4400, 4'h0, 22);
            send(16'h4400, 16'h3C00, 1'b0, 16'h4500, 4'h0, 23);
            send(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'h0, 24);
            send(16'h4500, 16'h3C00, 1'b1, 16'h4400, 4'h0, 25);
         end
         begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            check("in_ready low when full", 32'(bus.in_ready), 32'd0);
            check("out_valid held when full", 32'(bus.out_valid), 32'd1);
            @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three ops in flight; none of them may emerge.
      bus.out_ready = 1'b0;
      push_en = 1'b0;
      send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'h0, 90);
      send(16'h4000, 16'h4000, 1'b0, 16'h4400, 4'h0, 91);
      send(16'h4200, 16'h3C00, 1'b0, 16'h4400, 4'h0, 92);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      push_en = 1'b1;
      @(negedge clk);
      check("mid-op reset out_valid", 32'(bus.out_valid), 32'd0);
      check("mid-op reset result", 32'(bus.result), 32'd0);
      check("mid-op reset flags", 32'(bus.flags), 32'd0);
      check("mid-op reset in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      send(16'h4000, 16'h4000, 1'b0, 16'h4400, 4'h0, 30);
      drain();
      repeat (10) @(posedge clk);
      check("scoreboard empty", 32'(exp_q.size()), 32'd0);
      check("output count", 32'(n_pop), 32'(n_push));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
